dbus_sram_resp: RTL and testbench
=================================

DBUS_SRAM_RESP -- requirements
Module: dbus_sram_resp

Interface
REQ-001 SHALL have parameter DEPTH, default 4096, meaning memory size in 32-bit words (power of two, 16..65536).
REQ-002 SHALL have parameter LATENCY, default 2, meaning wait cycles between request acceptance and response (0..15).
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, meaning reset: asynchronous, active-low.
REQ-005 SHALL have port I_req, input, 1, meaning request valid from the core data bus.
REQ-006 SHALL have port I_we, input, 1, meaning 1 = write, 0 = read.
REQ-007 SHALL have port I_addr, input, 32, meaning byte address.
REQ-008 SHALL have port I_data, input, 32, meaning write data.
REQ-009 SHALL have port I_mask, input, 4, meaning byte-lane write enables; bit n covers data[8n+7:8n].
REQ-010 SHALL have port O_data, output, 32, meaning read data, valid only while O_ready=1.
REQ-011 SHALL have port O_ready, output, 1, meaning one-cycle completion pulse.

Function
REQ-012 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-013 In IDLE with I_req=1, the block SHALL capture I_we/I_addr/I_data/I_mask and go to WAIT, or to RESP if LATENCY=0.
REQ-014 In WAIT, the 4-bit latency counter SHALL count down from LATENCY-1, then move to RESP when it reaches 0.
REQ-015 RESP SHALL last exactly one cycle with O_ready=1, then return to IDLE unconditionally.
REQ-016 Request-to-ready latency SHALL be LATENCY+1 cycles, and throughput SHALL be one transaction per LATENCY+2 cycles.
REQ-017 I_req and all bus inputs SHALL be ignored outside IDLE; the core holds or re-issues requests itself.
REQ-018 Address decode: bit 31 SHALL be cleared, and word index = addr[log2(DEPTH)+1:2]; addr[1:0] SHALL be ignored.
REQ-019 Writes SHALL commit in the RESP cycle, updating only the byte lanes whose mask bit is 1.
REQ-020 A write with mask=0 SHALL complete with O_ready but leave memory unchanged.
REQ-021 For reads, O_data SHALL be the full addressed word in RESP.
REQ-022 O_data SHALL be 0 whenever O_ready=0, and SHALL be 0 for write responses.
REQ-023 A read issued immediately after a write to the same word SHALL return the newly written data.

Reset
REQ-024 On rst=0, the FSM SHALL go to IDLE, the counter to 0, O_ready to 0, O_data to 0, and the captured request to 0.
REQ-025 Memory contents SHALL NOT be reset.
REQ-026 Reset asserted in WAIT or RESP SHALL abort the transaction: no write commits and no O_ready is issued.
REQ-027 After rst deasserts, the first rising edge with I_req=1 SHALL be accepted.

Configuration
REQ-028 Macro DBUS_RESP_BUSERR_EN defined: the block SHALL add output port O_err (1 bit).
REQ-029 With DBUS_RESP_BUSERR_EN, O_err SHALL be 1 in RESP when masked addr >= 4*DEPTH; that write SHALL be suppressed and O_data forced to 0.
REQ-030 With DBUS_RESP_BUSERR_EN, O_err SHALL reset to 0 and SHALL be 0 outside RESP.
REQ-031 Macro undefined: there SHALL be no O_err port, and out-of-range addresses wrap modulo DEPTH words per REQ-018.

Structure
REQ-032 Shared package dbus_pkg SHALL hold constants MemAddrWidth=32, MemDataWidth=32, DbusMaskWidth=4, and the FSM state enum.
REQ-033 The memory array SHALL be a sub-module sram_bytewe: synchronous byte-write port, combinational-free registered read.
REQ-034 sram_bytewe read SHALL be issued on the cycle before RESP so that data is ready in RESP.

Verification
REQ-035 Bench SHALL cover: LATENCY=2, write 0x80000010 data 0xDEADBEEF mask 0xF, then read 0x80000010 -> O_ready 3 cycles after each req, read O_data=0xDEADBEEF.
REQ-036 Bench SHALL cover: write 0x10 data 0x11223344 mask 0x5 over 0xAAAAAAAA -> readback 0xAA22AA44.
REQ-037 Bench SHALL cover: LATENCY=0, back-to-back I_req held high for 6 cycles -> exactly 3 O_ready pulses, on cycles 1, 3, and 5.
REQ-038 Bench SHALL cover: rst=0 pulsed in WAIT during a write of 0x12345678 -> no O_ready, memory word unchanged.
REQ-039 Bench SHALL cover: DEPTH=16, read 0x40 -> without macro returns word 0; with DBUS_RESP_BUSERR_EN, O_err=1 and O_data=0.
REQ-040 Bench SHALL cover: write with mask 0x0 -> O_ready=1, O_data=0, memory unchanged.

Source files
------------

// File: rtl/dbus_pkg.sv
// Shared constants and FSM state type for the data-bus SRAM responder.
// Imported by the bus interface, the byte-write SRAM and the responder top.
package dbus_pkg;

  localparam int MemAddrWidth  = 32;
  localparam int MemDataWidth  = 32;
  localparam int DbusMaskWidth = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/dbus_sram_resp_if.sv
// Core data-bus handshake between a core (master) and the SRAM responder (slave).
// The optional bus-error output lives on the responder itself, not here.
interface dbus_sram_resp_if;
  import dbus_pkg::*;

  logic                     I_req;
  logic                     I_we;
  logic [MemAddrWidth-1:0]  I_addr;
  logic [MemDataWidth-1:0]  I_data;
  logic [DbusMaskWidth-1:0] I_mask;
  logic [MemDataWidth-1:0]  O_data;
  logic                     O_ready;

  modport master (
    output I_req,
    output I_we,
    output I_addr,
    output I_data,
    output I_mask,
    input  O_data,
    input  O_ready
  );

  modport slave (
    input  I_req,
    input  I_we,
    input  I_addr,
    input  I_data,
    input  I_mask,
    output O_data,
    output O_ready
  );

endinterface

// File: rtl/sram_bytewe.sv
// Single-port word SRAM with per-byte write enables and a registered read port.
// Contents are never reset; read data appears the cycle after re_i.
module sram_bytewe
  import dbus_pkg::*;
#(
  parameter int DEPTH     = 4096,
  parameter int AddrWidth = $clog2(DEPTH)
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic                     re_i,
  input  logic [AddrWidth-1:0]     addr_i,
  input  logic [DbusMaskWidth-1:0] be_i,
  input  logic [MemDataWidth-1:0]  wdata_i,
  output logic [MemDataWidth-1:0]  rdata_o
);

  logic [MemDataWidth-1:0] mem_q [DEPTH];
  logic [MemDataWidth-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < DbusMaskWidth; b++) begin
        if (be_i[b]) begin
          mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dbus_sram_resp.sv
// Data-bus SRAM responder: accepts one request in IDLE, waits LATENCY cycles, answers in RESP.
// Define DBUS_RESP_BUSERR_EN to add O_err and reject addresses beyond the memory.
module dbus_sram_resp
  import dbus_pkg::*;
#(
  parameter int DEPTH   = 4096,
  parameter int LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   rst,
`ifdef DBUS_RESP_BUSERR_EN
  output logic                   O_err,
`endif
  dbus_sram_resp_if.slave        bus
);

  localparam int         IdxWidth = $clog2(DEPTH);
  localparam logic [3:0] LatLoad  = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  state_e                   state_q;
  logic [3:0]               cnt_q;
  logic                     we_q;
  logic [MemAddrWidth-1:0]  addr_q;
  logic [MemDataWidth-1:0]  data_q;
  logic [DbusMaskWidth-1:0] mask_q;
  logic                     ready_q;

  logic                     goResp;
  logic                     sramWe;
  logic [IdxWidth-1:0]      sramAddr;
  logic [MemDataWidth-1:0]  sramRdata;
  logic                     unused_addrBits;

`ifdef DBUS_RESP_BUSERR_EN
  logic                     errPend_q;
  logic                     err_q;
  logic                     reqOutOfRange;

  // Bit 31 is dropped, so anything set between bit 30 and the top index bit is past the end.
  assign reqOutOfRange = |bus.I_addr[30:IdxWidth+2];
`endif

  // The cycle that will be followed by RESP; the SRAM read is launched here.
  always_comb begin
    goResp = 1'b0;
    case (state_q)
      IDLE:    goResp = bus.I_req && (LATENCY == 0);
      WAIT:    goResp = (cnt_q == 4'd0);
      default: goResp = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      mask_q    <= '0;
      ready_q   <= 1'b0;
`ifdef DBUS_RESP_BUSERR_EN
      errPend_q <= 1'b0;
      err_q     <= 1'b0;
`endif
    end else begin
      ready_q <= 1'b0;
`ifdef DBUS_RESP_BUSERR_EN
      err_q   <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (bus.I_req) begin
            we_q   <= bus.I_we;
            addr_q <= bus.I_addr;
            data_q <= bus.I_data;
            mask_q <= bus.I_mask;
            cnt_q  <= LatLoad;
`ifdef DBUS_RESP_BUSERR_EN
            errPend_q <= reqOutOfRange;
`endif
            if (goResp) begin
              state_q <= RESP;
              ready_q <= 1'b1;
`ifdef DBUS_RESP_BUSERR_EN
              err_q   <= reqOutOfRange;
`endif
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (goResp) begin
            state_q <= RESP;
            ready_q <= 1'b1;
`ifdef DBUS_RESP_BUSERR_EN
            err_q   <= errPend_q;
`endif
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // In IDLE the request has not been captured yet, so a zero-latency read uses the live address.
  assign sramAddr = (state_q == IDLE) ? bus.I_addr[IdxWidth+1:2] : addr_q[IdxWidth+1:2];

`ifdef DBUS_RESP_BUSERR_EN
  assign sramWe      = (state_q == RESP) && we_q && !err_q;
  assign bus.O_data  = (ready_q && !we_q && !err_q) ? sramRdata : '0;
  assign O_err       = err_q;
`else
  assign sramWe      = (state_q == RESP) && we_q;
  assign bus.O_data  = (ready_q && !we_q) ? sramRdata : '0;
`endif

  assign bus.O_ready = ready_q;

  // Byte offset and out-of-window bits of the captured address play no part in indexing.
  assign unused_addrBits = ^{addr_q[MemAddrWidth-1:IdxWidth+2], addr_q[1:0]};

  sram_bytewe #(
    .DEPTH (DEPTH)
  ) u_sram (
    .clk_i   (clk),
    .we_i    (sramWe),
    .re_i    (goResp),
    .addr_i  (sramAddr),
    .be_i    (mask_q),
    .wdata_i (data_q),
    .rdata_o (sramRdata)
  );

endmodule

// File: tb/tb_dbus_sram_resp.sv
// Directed testbench for dbus_sram_resp: three instances (LATENCY=2, LATENCY=0, DEPTH=16).
// Honours DBUS_RESP_BUSERR_EN for the bus-error expectations.
module tb_dbus_sram_resp;

  logic clk;
  logic rst;
  int   checkCount;
  int   passCount;

  logic err0;
  logic err1;
  logic err2;

  dbus_sram_resp_if b0 ();
  dbus_sram_resp_if b1 ();
  dbus_sram_resp_if b2 ();

  dbus_sram_resp #(.DEPTH(4096), .LATENCY(2)) dut (
    .clk (clk),
    .rst (rst),
`ifdef DBUS_RESP_BUSERR_EN
    .O_err (err0),
`endif
    .bus (b0.slave)
  );

  dbus_sram_resp #(.DEPTH(4096), .LATENCY(0)) dut0 (
    .clk (clk),
    .rst (rst),
`ifdef DBUS_RESP_BUSERR_EN
    .O_err (err1),
`endif
    .bus (b1.slave)
  );

  dbus_sram_resp #(.DEPTH(16), .LATENCY(2)) dut16 (
    .clk (clk),
    .rst (rst),
`ifdef DBUS_RESP_BUSERR_EN
    .O_err (err2),
`endif
    .bus (b2.slave)
  );

`ifndef DBUS_RESP_BUSERR_EN
  assign err0 = 1'b0;
  assign err1 = 1'b0;
  assign err2 = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int sel, input logic req, input logic we,
                       input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask);
    case (sel)
      0: begin b0.I_req = req; b0.I_we = we; b0.I_addr = addr; b0.I_data = data; b0.I_mask = mask; end
      1: begin b1.I_req = req; b1.I_we = we; b1.I_addr = addr; b1.I_data = data; b1.I_mask = mask; end
      default: begin b2.I_req = req; b2.I_we = we; b2.I_addr = addr; b2.I_data = data; b2.I_mask = mask; end
    endcase
  endtask

  task automatic sample(input int sel, output logic rdy, output logic [31:0] dat, output logic err);
    case (sel)
      0: begin rdy = b0.O_ready; dat = b0.O_data; err = err0; end
      1: begin rdy = b1.O_ready; dat = b1.O_data; err = err1; end
      default: begin rdy = b2.O_ready; dat = b2.O_data; err = err2; end
    endcase
  endtask

  // One request pulse; returns cycles until O_ready (-1 on timeout) and flags data seen without ready.
  task automatic runTxn(input int sel, input logic we, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] mask,
                        output int lat, output logic [31:0] rdata, output logic err, output logic leak);
    logic        r;
    logic [31:0] d;
    logic        e;
    lat   = -1;
    rdata = '0;
    err   = 1'b0;
    leak  = 1'b0;
    drive(sel, 1'b1, we, addr, data, mask);
    for (int n = 1; n <= 20 && lat < 0; n++) begin
      tick();
      if (n == 1) drive(sel, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      sample(sel, r, d, e);
      if (r === 1'b1) begin
        lat   = n;
        rdata = d;
        err   = e;
      end else if (d !== 32'h0) begin
        leak = 1'b1;
      end
    end
    if (lat >= 0) tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(2, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (3) tick();
    checkCount++;
    if (b0.O_ready !== 1'b0) $display("[TB] FAIL reset_ready0: got %b expected 0", b0.O_ready);
    else passCount++;
    checkCount++;
    if (b0.O_data !== 32'h0) $display("[TB] FAIL reset_data0: got %h expected 00000000", b0.O_data);
    else passCount++;
    checkCount++;
    if (b1.O_ready !== 1'b0) $display("[TB] FAIL reset_ready1: got %b expected 0", b1.O_ready);
    else passCount++;
    checkCount++;
    if (b2.O_ready !== 1'b0 || err2 !== 1'b0)
      $display("[TB] FAIL reset_ready2_err: got %b/%b expected 0/0", b2.O_ready, err2);
    else passCount++;
    rst = 1'b1;
  endtask

  task automatic test_write_read();
    int          lat;
    logic [31:0] rd;
    logic        er;
    logic        lk;
    runTxn(0, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, lat, rd, er, lk);
    checkCount++;
    if (lat !== 3) $display("[TB] FAIL wr_latency: got %0d expected 3", lat);
    else passCount++;
    checkCount++;
    if (rd !== 32'h0) $display("[TB] FAIL wr_resp_data: got %h expected 00000000", rd);
    else passCount++;
    runTxn(0, 1'b0, 32'h8000_0010, 32'h0, 4'h0, lat, rd, er, lk);
    checkCount++;
    if (lat !== 3) $display("[TB] FAIL rd_latency: got %0d expected 3", lat);
    else passCount++;
    checkCount++;
    if (rd !== 32'hDEAD_BEEF) $display("[TB] FAIL rd_data: got %h expected deadbeef", rd);
    else passCount++;
    checkCount++;
    if (lk !== 1'b0) $display("[TB] FAIL rd_data_without_ready: got %b expected 0", lk);
    else passCount++;
  endtask

  task automatic test_byte_mask();
    int          lat;
    logic [31:0] rd;
    logic        er;
    logic        lk;
    runTxn(0, 1'b1, 32'h0000_0010, 32'hAAAA_AAAA, 4'hF, lat, rd, er, lk);
    runTxn(0, 1'b1, 32'h0000_0010, 32'h1122_3344, 4'h5, lat, rd, er, lk);
    runTxn(0, 1'b0, 32'h0000_0010, 32'h0, 4'h0, lat, rd, er, lk);
    checkCount++;
    if (rd !== 32'hAA22_AA44) $display("[TB] FAIL mask5_readback: got %h expected aa22aa44", rd);
    else passCount++;
    runTxn(0, 1'b0, 32'h0000_0013, 32'h0, 4'h0, lat, rd, er, lk);
    checkCount++;
    if (rd !== 32'hAA22_AA44) $display("[TB] FAIL byte_offset_ignored: got %h expected aa22aa44", rd);
    else passCount++;
  endtask

  task automatic test_mask_zero();
    int          lat;
    logic [31:0] rd;
    logic        er;
    logic        lk;
    runTxn(0, 1'b1, 32'h0000_0020, 32'h5566_7788, 4'hF, lat, rd, er, lk);
    runTxn(0, 1'b1, 32'h0000_0020, 32'hFFFF_FFFF, 4'h0, lat, rd, er, lk);
    checkCount++;
    if (lat !== 3) $display("[TB] FAIL mask0_ready: got latency %0d expected 3", lat);
    else passCount++;
    checkCount++;
    if (rd !== 32'h0) $display("[TB] FAIL mask0_resp_data: got %h expected 00000000", rd);
    else passCount++;
    runTxn(0, 1'b0, 32'h0000_0020, 32'h0, 4'h0, lat, rd, er, lk);
    checkCount++;
    if (rd !== 32'h5566_7788) $display("[TB] FAIL mask0_unchanged: got %h expected 55667788", rd);
    else passCount++;
  endtask

  task automatic test_back_to_back();
    logic [9:0]  pattern;
    int          pulses;
    int          lat;
    logic [31:0] rd;
    logic        er;
    logic        lk;
    pattern = '0;
    pulses  = 0;
    drive(1, 1'b1, 1'b1, 32'h0000_0100, 32'h0BAD_F00D, 4'hF);
    for (int c = 0; c < 10; c++) begin
      if (c == 6) drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      pattern[c] = b1.O_ready;
      if (b1.O_ready === 1'b1) pulses++;
      tick();
    end
    checkCount++;
    if (pattern !== 10'b00_0010_1010)
      $display("[TB] FAIL b2b_ready_cycles: got %b expected 0000101010", pattern);
    else passCount++;
    checkCount++;
    if (pulses !== 3) $display("[TB] FAIL b2b_pulse_count: got %0d expected 3", pulses);
    else passCount++;
    runTxn(1, 1'b0, 32'h0000_0100, 32'h0, 4'h0, lat, rd, er, lk);
    checkCount++;
    if (lat !== 1 || rd !== 32'h0BAD_F00D)
      $display("[TB] FAIL lat0_read: got %0d/%h expected 1/0badf00d", lat, rd);
    else passCount++;
  endtask

  task automatic test_reset_abort();
    int          lat;
    int          seen;
    logic [31:0] rd;
    logic        er;
    logic        lk;
    seen = 0;
    runTxn(0, 1'b1, 32'h0000_0040, 32'hCAFE_BABE, 4'hF, lat, rd, er, lk);
    drive(0, 1'b1, 1'b1, 32'h0000_0040, 32'h1234_5678, 4'hF);
    tick();
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    #2 rst = 1'b0;
    #3 rst = 1'b1;
    for (int n = 0; n < 8; n++) begin
      if (b0.O_ready === 1'b1) seen++;
      tick();
    end
    checkCount++;
    if (seen !== 0) $display("[TB] FAIL abort_no_ready: got %0d pulses expected 0", seen);
    else passCount++;
    runTxn(0, 1'b0, 32'h0000_0040, 32'h0, 4'h0, lat, rd, er, lk);
    checkCount++;
    if (rd !== 32'hCAFE_BABE) $display("[TB] FAIL abort_mem_unchanged: got %h expected cafebabe", rd);
    else passCount++;
    checkCount++;
    if (lat !== 3) $display("[TB] FAIL post_reset_accept: got %0d expected 3", lat);
    else passCount++;
  endtask

  task automatic test_addr_range();
    int          lat;
    logic [31:0] rd;
    logic        er;
    logic        lk;
    runTxn(2, 1'b1, 32'h0000_0000, 32'h600D_CAFE, 4'hF, lat, rd, er, lk);
    runTxn(2, 1'b0, 32'h8000_0000, 32'h0, 4'h0, lat, rd, er, lk);
    checkCount++;
    if (rd !== 32'h600D_CAFE || er !== 1'b0)
      $display("[TB] FAIL bit31_cleared: got %h/%b expected 600dcafe/0", rd, er);
    else passCount++;
    runTxn(2, 1'b0, 32'h0000_0040, 32'h0, 4'h0, lat, rd, er, lk);
`ifdef DBUS_RESP_BUSERR_EN
    checkCount++;
    if (er !== 1'b1 || rd !== 32'h0 || lat !== 3)
      $display("[TB] FAIL oor_read_err: got err %b data %h lat %0d expected 1/00000000/3", er, rd, lat);
    else passCount++;
    runTxn(2, 1'b1, 32'h0000_0040, 32'hBAD0_0BAD, 4'hF, lat, rd, er, lk);
    checkCount++;
    if (er !== 1'b1) $display("[TB] FAIL oor_write_err: got %b expected 1", er);
    else passCount++;
    runTxn(2, 1'b0, 32'h0000_0000, 32'h0, 4'h0, lat, rd, er, lk);
    checkCount++;
    if (rd !== 32'h600D_CAFE || er !== 1'b0)
      $display("[TB] FAIL oor_write_suppressed: got %h/%b expected 600dcafe/0", rd, er);
    else passCount++;
`else
    checkCount++;
    if (rd !== 32'h600D_CAFE || lat !== 3)
      $display("[TB] FAIL oor_read_wraps: got %h lat %0d expected 600dcafe/3", rd, lat);
    else passCount++;
`endif
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    test_reset();
    test_write_read();
    test_byte_mask();
    test_mask_zero();
    test_back_to_back();
    test_reset_abort();
    test_addr_range();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
